load_store_unit: RTL and testbench
==================================

# load_store_unit

Core-side initiator for data-memory load/store traffic. Sits between the MEM pipeline stage and the word-organised data memory. Accepts one byte, halfword or word request at a time. Turns each request into one or two word-aligned memory transactions with byte enables, then returns sign- or zero-extended load data through a valid/ready handshake.

## Interface
Parameters:
- ADDR_W, 32, byte-address width; memory word index is ADDR_W-2 bits.

Ports:
- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-low; the block is held in reset while reset=0
- req_valid  in  1  pipeline request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_write  in  1  1=store, 0=load
- req_funct3  in  3  RISC-V funct3 of the load/store
- req_addr  in  ADDR_W  byte address from ALU
- req_wdata  in  32  store data (LSB-aligned)
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_error  out  1  qualifies resp_valid: illegal funct3 or unsupported misalignment
- mem_req  out  1  memory transaction request, held until mem_ack
- mem_we  out  1  write transaction
- mem_addr  out  ADDR_W  word-aligned address (bits [1:0]=0)
- mem_wdata  out  32  lane-positioned write data
- mem_be  out  4  byte enables
- mem_ack  in  1  transaction done; mem_rdata valid in the same cycle
- mem_rdata  in  32  read word

## Operation
- States: IDLE, ACC0, ACC1, RESP. req_ready=1 only in IDLE.
- IDLE: on handshake, register funct3, addr, wdata and write → ACC0. Exception: a request with illegal funct3 (load 011/110/111; store ≥011) goes → RESP with error and no memory access.
- Size: byte for funct3[1:0]=00, half for 01, word for 10. Offset = addr[1:0]. Lane mask = size mask << offset; this is 8 bits.
- ACC0: mem_addr={addr[ADDR_W-1:2],2'b00}, mem_be=mask[3:0], mem_wdata=(wdata<<8*offset)[31:0]. On mem_ack, capture rdata into low word. If mask[7:4]≠0 → ACC1, else → RESP.
- ACC1: mem_addr=ACC0 address+4, wrapping modulo 2^ADDR_W (0xFFFFFFFC → 0x00000000). mem_be=mask[7:4], mem_wdata=(wdata<<8*offset)[63:32]. On mem_ack, capture high word → RESP.
- Load result: ({high,low} >> 8*offset) truncated to size. It is sign-extended for funct3[2]=0 and zero-extended for funct3[2]=1.
- RESP: resp_valid=1 for exactly one cycle → IDLE.
- A split store is not atomic; the first word is written even if reset intervenes before the second.
- mem_req, mem_we, mem_addr, mem_be and mem_wdata are stable while mem_req=1 and mem_ack=0.

## Timing
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, mem_req=0, mem_we=0, mem_addr=0, mem_be=0, mem_wdata=0.
- Aligned access with zero-wait memory: handshake cycle N, mem_req cycle N+1 (ack same cycle), resp_valid cycle N+2, req_ready cycle N+3.
- Split access adds one cycle plus wait states per word. Each wait state adds one cycle.
- Illegal funct3: resp_valid with resp_error=1 at N+1; no mem_req.
- mem_ack outside ACC0/ACC1 is ignored.
- Reset assertion mid-operation: all outputs go to reset values immediately (asynchronously). The in-flight transaction is abandoned. First acceptance is possible on the first clock edge after release.

## Configuration
- MISALIGNED_SPLIT_EN defined: an access crossing a word boundary uses ACC1 as above.
- MISALIGNED_SPLIT_EN undefined: any access whose mask[7:4]≠0 makes no memory access. The block goes IDLE→RESP, with resp_error=1 at N+1. The ACC1 state and the high-word register are not built.

## Structure
- Shared package lsu_pkg holds:
  - funct3 constants: LB, LH, LW, LBU, LHU, SB, SH, SW
  - state encoding: IDLE, ACC0, ACC1, RESP
  - size encoding
- One combinational sub-module, lsu_align, computes lane mask, shifted store data, and the load extract/extend. The FSM and registers stay in load_store_unit.

## Test plan
- LW 0x100, zero-wait memory returns 0xDEADBEEF → mem_be=1111, resp_rdata=0xDEADBEEF, resp_valid at N+2, resp_error=0.
- LB then LBU at 0x103, word 0x80112233 → resp_rdata 0xFFFFFF80, then 0x00000080.
- SH 0x102 wdata 0x1234ABCD → mem_we=1, mem_addr=0x100, mem_be=1100, mem_wdata=0xABCD0000; resp_rdata=0.
- LW 0xFFE, words 0xAAAA_xxxx at 0xFFC and 0xyyyy_BBBB at 0x1000:
  - with MISALIGNED_SPLIT_EN: be 1100 then 0011, resp_rdata=0xBBBBAAAA.
  - without the macro: no mem_req, resp_error=1 at N+1.
- Load funct3=011 → resp_error=1, resp_rdata=0, no mem_req.
- LW 0x200, memory inserts 3 wait states, reset pulled low during the second wait → mem_req=0 immediately. After release, req_ready=1 and a new LW completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RISC-V load/store funct3 codes,
// FSM state encoding, access-size encoding and the funct3 legality check.
package lsu_pkg;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;
   localparam logic [2:0] SB  = 3'b000;
   localparam logic [2:0] SH  = 3'b001;
   localparam logic [2:0] SW  = 3'b010;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ACC0 = 2'd1;
   localparam logic [1:0] ACC1 = 2'd2;
   localparam logic [1:0] RESP = 2'd3;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'b00,
      SZ_HALF = 2'b01,
      SZ_WORD = 2'b10
   } lsu_size_e;

   function automatic logic f3_legal(input logic write, input logic [2:0] f3);
      if (write)
         return f3 inside {SB, SH, SW};
      return f3 inside {LB, LH, LW, LBU, LHU};
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment for the load/store unit: 8-bit lane mask across two
// words, store data shifted into lane position, and load extract/extend from
// the {high, low} word pair.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  offset,
   input  logic [31:0] wdata,
   input  logic [31:0] lo_word,
   input  logic [31:0] hi_word,
   output logic [7:0]  mask,
   output logic [63:0] wdata_sh,
   output logic [31:0] load_data
);

   lsu_size_e   size;
   logic [7:0]  base_mask;
   logic [31:0] rd_sh;
   logic        sext;

   // Lane mask, store shift and load extension for the current access.
   always_comb begin
      size = lsu_size_e'(funct3[1:0]);
      sext = ~funct3[2];
      case (size)
         SZ_BYTE: base_mask = 8'h01;
         SZ_HALF: base_mask = 8'h03;
         default: base_mask = 8'h0F;
      endcase
      mask     = base_mask << offset;
      wdata_sh = {32'h0, wdata} << {offset, 3'b000};
      rd_sh    = 32'({hi_word, lo_word} >> {offset, 3'b000});
      case (size)
         SZ_BYTE: load_data = {{24{rd_sh[7] & sext}}, rd_sh[7:0]};
         SZ_HALF: load_data = {{16{rd_sh[15] & sext}}, rd_sh[15:0]};
         default: load_data = rd_sh;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one load/store at a time from the MEM stage and
// issues one or two word-aligned memory transactions with byte enables.
// Build option: MISALIGNED_SPLIT_EN enables word-crossing accesses via ACC1;
// without it such accesses complete immediately with resp_error.
//
// state | meaning
// IDLE  | ready for a request
// ACC0  | transaction on the first (or only) word
// ACC1  | transaction on the following word of a split access
// RESP  | one-cycle completion pulse
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_error,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_be,
   input  logic              mem_ack,
   input  logic [31:0]       mem_rdata
);

   logic [1:0]        state_q, state_d;
   logic [2:0]        f3_q, f3_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              write_q, write_d;
   logic              err_q, err_d;
   logic [31:0]       lo_q, lo_d;
`ifdef MISALIGNED_SPLIT_EN
   logic [31:0]       hi_q, hi_d;
`endif

   logic              idle;
   logic [2:0]        al_f3;
   logic [1:0]        al_off;
   logic [31:0]       al_hi;
   logic [7:0]        mask;
   logic [63:0]       wdata_sh;
   logic [31:0]       load_data;
   logic [ADDR_W-1:0] word_addr;

   // In IDLE the mask is needed for the incoming request (error screening),
   // afterwards for the registered one.
   always_comb begin
      idle      = (state_q == IDLE);
      al_f3     = idle ? req_funct3 : f3_q;
      al_off    = idle ? req_addr[1:0] : addr_q[1:0];
      word_addr = {addr_q[ADDR_W-1:2], 2'b00};
`ifdef MISALIGNED_SPLIT_EN
      al_hi     = hi_q;
`else
      al_hi     = 32'h0;
`endif
   end

   lsu_align u_align (
      .funct3    (al_f3),
      .offset    (al_off),
      .wdata     (wdata_q),
      .lo_word   (lo_q),
      .hi_word   (al_hi),
      .mask      (mask),
      .wdata_sh  (wdata_sh),
      .load_data (load_data)
   );

   // Next-state and request capture.
   always_comb begin
      state_d = state_q;
      f3_d    = f3_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      write_d = write_q;
      err_d   = err_q;
      lo_d    = lo_q;
`ifdef MISALIGNED_SPLIT_EN
      hi_d    = hi_q;
`endif
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               f3_d    = req_funct3;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               write_d = req_write;
               err_d   = ~f3_legal(req_write, req_funct3);
`ifndef MISALIGNED_SPLIT_EN
               if (mask[7:4] != 4'h0)
                  err_d = 1'b1;
`endif
               state_d = err_d ? RESP : ACC0;
            end
         end
         ACC0: begin
            if (mem_ack) begin
               lo_d = mem_rdata;
`ifdef MISALIGNED_SPLIT_EN
               state_d = (mask[7:4] != 4'h0) ? ACC1 : RESP;
`else
               state_d = RESP;
`endif
            end
         end
         ACC1: begin
`ifdef MISALIGNED_SPLIT_EN
            if (mem_ack) begin
               hi_d    = mem_rdata;
               state_d = RESP;
            end
`else
            state_d = IDLE;
`endif
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are decoded from state so reset clears them asynchronously.
   always_comb begin
      req_ready  = idle;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_be     = 4'h0;
      mem_wdata  = 32'h0;
      case (state_q)
         ACC0: begin
            mem_req   = 1'b1;
            mem_we    = write_q;
            mem_addr  = word_addr;
            mem_be    = mask[3:0];
            mem_wdata = wdata_sh[31:0];
         end
         ACC1: begin
            mem_req   = 1'b1;
            mem_we    = write_q;
            mem_addr  = word_addr + ADDR_W'(4);
            mem_be    = mask[7:4];
            mem_wdata = wdata_sh[63:32];
         end
         default: ;
      endcase
      resp_valid = (state_q == RESP);
      resp_error = resp_valid & err_q;
      resp_rdata = (resp_valid && !err_q && !write_q) ? load_data : 32'h0;
   end

   // State and request registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         f3_q    <= 3'h0;
         addr_q  <= '0;
         wdata_q <= 32'h0;
         write_q <= 1'b0;
         err_q   <= 1'b0;
         lo_q    <= 32'h0;
`ifdef MISALIGNED_SPLIT_EN
         hi_q    <= 32'h0;
`endif
      end else begin
         state_q <= state_d;
         f3_q    <= f3_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         write_q <= write_d;
         err_q   <= err_d;
         lo_q    <= lo_d;
`ifdef MISALIGNED_SPLIT_EN
         hi_q    <= hi_d;
`endif
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit. Works with and without MISALIGNED_SPLIT_EN.
// Expected results come from a byte-level model of the access rules and a
// byte-addressed memory that also serves the DUT's transactions.
module tb_load_store_unit;
   import lsu_pkg::*;

`ifdef MISALIGNED_SPLIT_EN
   localparam bit SPLIT = 1'b1;
`else
   localparam bit SPLIT = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
   logic [2:0]  req_funct3 = 3'h0;
   logic [31:0] req_addr = 32'h0, req_wdata = 32'h0;
   logic        resp_valid, resp_error;
   logic [31:0] resp_rdata;
   logic        mem_req, mem_we, mem_ack;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [3:0]  mem_be;

   int n_assert = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   load_store_unit #(.ADDR_W(32)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack),
      .mem_rdata(mem_rdata)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Byte-addressed memory; unwritten bytes read a fixed address hash.
   logic [7:0] mem_b [logic [31:0]];

   function automatic logic [7:0] rd_b(input logic [31:0] a);
      if (mem_b.exists(a))
         return mem_b[a];
      return a[7:0] ^ a[15:8] ^ 8'h5C;
   endfunction

   task automatic set_word(input logic [31:0] a, input logic [31:0] w);
      for (int i = 0; i < 4; i++)
         mem_b[a + 32'(i)] = w[8*i +: 8];
   endtask

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wd;
   } txn_t;

   txn_t log_q[$];
   int   waits = 0;
   int   wcnt  = 0;

   // Memory responder: acks after 'waits' wait cycles, logs every transaction.
   initial begin
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      forever begin
         @(negedge clk);
         mem_ack = 1'b0;
         if (mem_req) begin
            if (wcnt < waits) begin
               wcnt++;
            end else begin
               wcnt    = 0;
               mem_ack = 1'b1;
               for (int i = 0; i < 4; i++)
                  mem_rdata[8*i +: 8] = rd_b(mem_addr + 32'(i));
               if (mem_we)
                  for (int i = 0; i < 4; i++)
                     if (mem_be[i]) mem_b[mem_addr + 32'(i)] = mem_wdata[8*i +: 8];
               log_q.push_back('{mem_we, mem_addr, mem_be, mem_wdata});
            end
         end else begin
            wcnt = 0;
         end
      end
   end

   // Reference model: expected latency, error, data and transaction list.
   int          e_lat;
   logic        e_err;
   logic [31:0] e_rdata;
   txn_t        e_tx[$];

   task automatic model(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd);
      int          size, off;
      bit          legal, split;
      logic [7:0]  lanes;
      logic [31:0] val, base;
      logic [63:0] wd64;
      size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      off   = int'(a[1:0]);
      legal = wr ? (f3 < 3'd3) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      split = (off + size) > 4;
      e_tx.delete();
      e_err   = 1'b0;
      e_rdata = 32'h0;
      if (!legal || (split && !SPLIT)) begin
         e_err = 1'b1;
         e_lat = 1;
         return;
      end
      lanes = 8'h0;
      val   = 32'h0;
      for (int i = 0; i < size; i++) begin
         lanes[off + i] = 1'b1;
         val = val | (32'(rd_b(a + 32'(i))) << (8 * i));
      end
      if (!f3[2] && size < 4 && val[8*size-1])
         val = val | ~((32'h1 << (8 * size)) - 32'h1);
      wd64 = 64'(wd) << (8 * off);
      base = a & ~32'h3;
      e_tx.push_back('{wr, base, lanes[3:0], wd64[31:0]});
      if (split)
         e_tx.push_back('{wr, base + 32'h4, lanes[7:4], wd64[63:32]});
      e_rdata = wr ? 32'h0 : val;
      e_lat   = 1 + e_tx.size() * (1 + waits);
   endtask

   task automatic run_req(input string tag, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd);
      int k;
      bit got;
      model(wr, f3, a, wd);
      log_q.delete();
      @(negedge clk);
      chk({tag, " ready"}, req_ready, 1'b1);
      req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd;
      k   = 0;
      got = 0;
      while (!got && k < 60) begin
         @(negedge clk);
         k++;
         req_valid = 1'b0;
         req_addr  = $urandom;
         req_wdata = $urandom;
         req_funct3 = 3'($urandom);
         if (resp_valid) got = 1;
      end
      chk({tag, " latency"}, k, e_lat);
      chk({tag, " error"}, resp_error, e_err);
      chk({tag, " rdata"}, resp_rdata, e_rdata);
      chk({tag, " txn_count"}, log_q.size(), e_tx.size());
      for (int i = 0; i < e_tx.size() && i < log_q.size(); i++) begin
         chk({tag, " txn_we"},   log_q[i].we,   e_tx[i].we);
         chk({tag, " txn_addr"}, log_q[i].addr, e_tx[i].addr);
         chk({tag, " txn_be"},   log_q[i].be,   e_tx[i].be);
         chk({tag, " txn_wd"},   log_q[i].wd,   e_tx[i].wd);
      end
      @(negedge clk);
      chk({tag, " pulse_end"}, resp_valid, 1'b0);
      chk({tag, " ready_after"}, req_ready, 1'b1);
   endtask

   initial begin
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] a;

      // Reset values while reset is held low.
      #1;
      chk("rst req_ready",  req_ready,  1'b1);
      chk("rst resp_valid", resp_valid, 1'b0);
      chk("rst resp_rdata", resp_rdata, 32'h0);
      chk("rst resp_error", resp_error, 1'b0);
      chk("rst mem_req",    mem_req,    1'b0);
      chk("rst mem_we",     mem_we,     1'b0);
      chk("rst mem_addr",   mem_addr,   32'h0);
      chk("rst mem_be",     mem_be,     4'h0);
      chk("rst mem_wdata",  mem_wdata,  32'h0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      // Directed cases.
      waits = 0;
      set_word(32'h100, 32'hDEADBEEF);
      run_req("lw_100", 1'b0, LW, 32'h100, 32'h0);
      set_word(32'h100, 32'h80112233);
      run_req("lb_103", 1'b0, LB, 32'h103, 32'h0);
      run_req("lbu_103", 1'b0, LBU, 32'h103, 32'h0);
      run_req("sh_102", 1'b1, SH, 32'h102, 32'h1234ABCD);
      run_req("lw_100_after_sh", 1'b0, LW, 32'h100, 32'h0);
      set_word(32'h0FFC, 32'hAAAA1111);
      set_word(32'h1000, 32'h2222BBBB);
      run_req("lw_ffe", 1'b0, LW, 32'h0FFE, 32'h0);
      run_req("ld_f3_011", 1'b0, 3'b011, 32'h100, 32'h0);
      run_req("st_f3_100", 1'b1, 3'b100, 32'h100, 32'h55555555);
      run_req("lh_103", 1'b0, LH, 32'h103, 32'h0);
      run_req("lw_wrap", 1'b0, LW, 32'hFFFFFFFE, 32'h0);
      waits = 2;
      run_req("sw_wait", 1'b1, SW, 32'h40, 32'hCAFEF00D);
      run_req("lw_wait", 1'b0, LW, 32'h40, 32'h0);

      // Randomized traffic.
      for (int n = 0; n < 80; n++) begin
         wr    = 1'($urandom);
         f3    = 3'($urandom);
         a     = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF8 + 32'($urandom_range(0, 7)))
                                             : 32'($urandom_range(0, 63));
         waits = $urandom_range(0, 2);
         run_req("rand", wr, f3, a, $urandom);
      end

      // Reset during the second wait state of a load.
      waits = 3;
      log_q.delete();
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_funct3 = LW; req_addr = 32'h200; req_wdata = 32'h0;
      @(negedge clk);
      req_valid = 1'b0;
      chk("rst_mid mem_req_before", mem_req, 1'b1);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_mid mem_req",    mem_req,    1'b0);
      chk("rst_mid mem_addr",   mem_addr,   32'h0);
      chk("rst_mid mem_be",     mem_be,     4'h0);
      chk("rst_mid resp_valid", resp_valid, 1'b0);
      chk("rst_mid req_ready",  req_ready,  1'b1);
      chk("rst_mid no_txn",     log_q.size(), 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      waits = 0;
      set_word(32'h200, 32'h0BADF00D);
      run_req("lw_after_rst", 1'b0, LW, 32'h200, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
